btn_event_decoder: RTL and testbench

//   Consumes a clean, debounced button level and classifies each press as

---
 rtl/btn_pkg.sv | 31 +++
 rtl/ms_tick_gen.sv | 29 ++
 rtl/btn_event_decoder.sv | 158 +++++++++++++++
 tb/tb_btn_event_decoder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the button event decoder: FSM state encoding,
// default timing constants (clk cycles per tick, durations in ms ticks)
// and a small helper used to size the millisecond counter.
package btn_pkg;

    typedef logic [2:0] btn_state_t;

    // state  | meaning
    // IDLE   | button released, nothing pending
    // PRESS1 | first press in progress, timing towards long
    // GAP    | released after a short press, waiting for a possible second press
    // PRESS2 | second press of a double-click in progress
    // HELD   | long press reached, waiting for release
    localparam btn_state_t IDLE   = 3'd0;
    localparam btn_state_t PRESS1 = 3'd1;
    localparam btn_state_t GAP    = 3'd2;
    localparam btn_state_t PRESS2 = 3'd3;
    localparam btn_state_t HELD   = 3'd4;

    localparam int TICK_COUNT = 100000;
    localparam int LONG_MS    = 800;
    localparam int DOUBLE_MS  = 250;
    localparam int REPEAT_MS  = 100;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running millisecond prescaler. A down-counter that reloads at its
// terminal count; o_tick is high for one clk every TICK_COUNT cycles.
// The counter resets to 0, so the first tick is seen on the first clk
// after reset is released.
module ms_tick_gen #(
    parameter int TICK_COUNT = btn_pkg::TICK_COUNT
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);

    localparam int CNT_W = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;

    logic [CNT_W-1:0] cnt;

    // Count down, reload on terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (cnt == '0)
            cnt <= CNT_W'(TICK_COUNT - 1);
        else
            cnt <= cnt - 1'b1;
    end

    assign o_tick = (cnt == '0);

endmodule

// File: rtl/btn_event_decoder.sv
// Classifies a debounced button level into short / long / double-click
// events, each a registered one-clk pulse. Timing is counted in ms ticks
// from ms_tick_gen. An edge always takes priority over a timeout that
// lands in the same cycle.
// Build option: define BTN_AUTO_REPEAT_EN to enable o_repeat pulses while
// the button is held past a long press; otherwise o_repeat is tied low.
module btn_event_decoder #(
    parameter int TICK_COUNT = btn_pkg::TICK_COUNT,
    parameter int LONG_MS    = btn_pkg::LONG_MS,
    parameter int DOUBLE_MS  = btn_pkg::DOUBLE_MS,
    parameter int REPEAT_MS  = btn_pkg::REPEAT_MS
) (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_short,
    output logic o_long,
    output logic o_double,
    output logic o_repeat,
    output logic o_busy
);

    import btn_pkg::*;

    localparam int MS_W = $clog2(max3(LONG_MS, DOUBLE_MS, REPEAT_MS) + 1);

    logic            tick;
    logic            level_q;
    logic            rise;
    logic            fall;
    btn_state_t      state;
    btn_state_t      state_nxt;
    logic [MS_W-1:0] ms_cnt;
    logic            long_due;
    logic            gap_due;
    logic            short_d;
    logic            long_d;
    logic            double_d;

    ms_tick_gen #(
        .TICK_COUNT(TICK_COUNT)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .o_tick (tick)
    );

    assign rise     = i_level & ~level_q;
    assign fall     = ~i_level & level_q;
    assign long_due = tick && (ms_cnt == MS_W'(LONG_MS - 1));
    assign gap_due  = tick && (ms_cnt == MS_W'(DOUBLE_MS - 1));

    // Previous level for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            level_q <= 1'b0;
        else
            level_q <= i_level;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; edges are tested before timeouts.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rise) state_nxt = PRESS1;
            PRESS1:  if (fall) state_nxt = GAP;
                     else if (long_due) state_nxt = HELD;
            GAP:     if (rise) state_nxt = PRESS2;
                     else if (gap_due) state_nxt = IDLE;
            PRESS2:  if (fall) state_nxt = IDLE;
                     else if (long_due) state_nxt = HELD;
            HELD:    if (fall) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef BTN_AUTO_REPEAT_EN
    logic rep_due;
    logic repeat_d;
    logic repeat_q;

    assign rep_due = tick && (ms_cnt == MS_W'(REPEAT_MS - 1));
`endif

    // Event decode from the current state; a same-cycle edge suppresses timeouts.
    always_comb begin
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
        repeat_d = 1'b0;
`endif
        case (state)
            PRESS1: long_d = !fall && long_due;
            GAP:    short_d = !rise && gap_due;
            PRESS2: begin
                double_d = fall;
                long_d   = !fall && long_due;
            end
`ifdef BTN_AUTO_REPEAT_EN
            HELD:   repeat_d = !fall && rep_due;
`endif
            default: ;
        endcase
    end

    // Millisecond counter: cleared on any state change, saturating otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ms_cnt <= '0;
        else if (state_nxt != state)
            ms_cnt <= '0;
`ifdef BTN_AUTO_REPEAT_EN
        else if (repeat_d)
            ms_cnt <= '0;
`endif
        else if (tick && (ms_cnt != '1))
            ms_cnt <= ms_cnt + MS_W'(1);
    end

    // Registered one-clk event pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_short  <= 1'b0;
            o_long   <= 1'b0;
            o_double <= 1'b0;
        end else begin
            o_short  <= short_d;
            o_long   <= long_d;
            o_double <= double_d;
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    // Registered auto-repeat pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            repeat_q <= 1'b0;
        else
            repeat_q <= repeat_d;
    end

    assign o_repeat = repeat_q;
`else
    assign o_repeat = 1'b0;
`endif

    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_btn_event_decoder.sv
// Self-checking bench for btn_event_decoder with short timing
// (TICK_COUNT=4, LONG_MS=10, DOUBLE_MS=5, REPEAT_MS=3).
module tb_btn_event_decoder;

    localparam int TC = 4;
    localparam int LM = 10;
    localparam int DM = 5;
    localparam int RM = 3;
`ifdef BTN_AUTO_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic i_level;
    logic o_short, o_long, o_double, o_repeat, o_busy;

    always #5 clk = ~clk;

    btn_event_decoder #(
        .TICK_COUNT(TC),
        .LONG_MS   (LM),
        .DOUBLE_MS (DM),
        .REPEAT_MS (RM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_level  (i_level),
        .o_short  (o_short),
        .o_long   (o_long),
        .o_double (o_double),
        .o_repeat (o_repeat),
        .o_busy   (o_busy)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: what the button is doing, and how many ms ticks have
    // elapsed since that activity began.
    typedef enum int {M_QUIET, M_FIRST_DOWN, M_WAIT_SECOND, M_SECOND_DOWN, M_HOLDING} activity_t;
    activity_t  m_act;
    int         m_elapsed;
    logic       m_prev;
    int         m_cycle;
    logic [4:0] m_exp;      // {short, long, double, repeat, busy}
    int         ev_cnt[4];  // short, long, double, repeat

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic lvl);
        bit        tick, pressed, released, e_s, e_l, e_d, e_r;
        int        nth;
        activity_t nxt;
        tick     = (m_cycle % TC) == 0;
        pressed  = lvl && !m_prev;
        released = !lvl && m_prev;
        nth      = tick ? m_elapsed + 1 : -1;   // ordinal of this tick within the activity
        nxt      = m_act;
        e_s = 0; e_l = 0; e_d = 0; e_r = 0;
        case (m_act)
            M_QUIET:       if (pressed) nxt = M_FIRST_DOWN;
            M_FIRST_DOWN:  if (released) nxt = M_WAIT_SECOND;
                           else if (nth == LM) begin e_l = 1; nxt = M_HOLDING; end
            M_WAIT_SECOND: if (pressed) nxt = M_SECOND_DOWN;
                           else if (nth == DM) begin e_s = 1; nxt = M_QUIET; end
            M_SECOND_DOWN: if (released) begin e_d = 1; nxt = M_QUIET; end
                           else if (nth == LM) begin e_l = 1; nxt = M_HOLDING; end
            M_HOLDING:     if (released) nxt = M_QUIET;
                           else if (REP_EN && nth == RM) e_r = 1;
            default:       nxt = M_QUIET;
        endcase
        if (nxt != m_act || e_r) m_elapsed = 0;
        else if (tick)           m_elapsed = m_elapsed + 1;
        m_exp   = {e_s, e_l, e_d, e_r, nxt != M_QUIET};
        m_act   = nxt;
        m_prev  = lvl;
        m_cycle = m_cycle + 1;
    endtask

    // One clk: drive at negedge, model the edge, compare 1 time unit later.
    task automatic step(input logic lvl);
        i_level = lvl;
        @(posedge clk);
        model_edge(lvl);
        #1;
        check("model", {27'd0, o_short, o_long, o_double, o_repeat, o_busy}, {27'd0, m_exp});
        ev_cnt[0] += int'(o_short);
        ev_cnt[1] += int'(o_long);
        ev_cnt[2] += int'(o_double);
        ev_cnt[3] += int'(o_repeat);
        @(negedge clk);
    endtask

    task automatic clear_counts();
        for (int j = 0; j < 4; j++) ev_cnt[j] = 0;
    endtask

    // Asynchronous reset applied mid-cycle; outputs must drop at once.
    task automatic do_reset();
        rst     = 1'b1;
        i_level = 1'b0;
        #1;
        check("rst_outputs", {27'd0, o_short, o_long, o_double, o_repeat, o_busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        m_act     = M_QUIET;
        m_elapsed = 0;
        m_prev    = 1'b0;
        m_cycle   = 0;
    endtask

    task automatic expect_quiet_after_reset(input string name);
        clear_counts();
        repeat (40) step(1'b0);
        check(name, ev_cnt[0] + ev_cnt[1] + ev_cnt[2] + ev_cnt[3], 0);
    endtask

    typedef struct {
        logic lvl;
        int   cycles;
        int   e_s;
        int   e_l;
        int   e_d;
        int   e_r;
        logic busy_end;
    } vec_t;

    vec_t tbl[13];

    initial begin
        bit   seen;
        int   n;
        logic lvl;

        // Segments with hand-computed event counts (ticks on every 4th clk).
        tbl[0]  = '{1'b0,  3, 0, 0, 0, 0, 1'b0};  // idle
        tbl[1]  = '{1'b1, 12, 0, 0, 0, 0, 1'b1};  // press 3 ticks
        tbl[2]  = '{1'b0, 30, 1, 0, 0, 0, 1'b0};  // release -> short
        tbl[3]  = '{1'b1,  8, 0, 0, 0, 0, 1'b1};  // first press
        tbl[4]  = '{1'b0,  8, 0, 0, 0, 0, 1'b1};  // gap
        tbl[5]  = '{1'b1,  8, 0, 0, 0, 0, 1'b1};  // second press
        tbl[6]  = '{1'b0, 30, 0, 0, 1, 0, 1'b0};  // release -> double only
        tbl[7]  = '{1'b1, 80, 0, 1, 0, REP_EN ? 3 : 0, 1'b1};  // hold 20 ticks
        tbl[8]  = '{1'b0, 20, 0, 0, 0, 0, 1'b0};  // release from HELD
        tbl[9]  = '{1'b1,  8, 0, 0, 0, 0, 1'b1};  // click
        tbl[10] = '{1'b0,  8, 0, 0, 0, 0, 1'b1};
        tbl[11] = '{1'b1, 48, 0, 1, 0, 0, 1'b1};  // second press held -> long
        tbl[12] = '{1'b0, 20, 0, 0, 0, 0, 1'b0};  // no double afterwards

        rst     = 1'b0;
        i_level = 1'b0;
        @(negedge clk);

        do_reset();
        for (int i = 0; i < 13; i++) begin
            clear_counts();
            repeat (tbl[i].cycles) step(tbl[i].lvl);
            check($sformatf("row%0d_short", i),  ev_cnt[0], tbl[i].e_s);
            check($sformatf("row%0d_long", i),   ev_cnt[1], tbl[i].e_l);
            check($sformatf("row%0d_double", i), ev_cnt[2], tbl[i].e_d);
            check($sformatf("row%0d_repeat", i), ev_cnt[3], tbl[i].e_r);
            check($sformatf("row%0d_busy", i),   {31'd0, o_busy}, {31'd0, tbl[i].busy_end});
        end

        // o_double one clk after the second fall, lasting one clk.
        do_reset();
        step(1'b0);
        repeat (8) step(1'b1);
        repeat (8) step(1'b0);
        repeat (8) step(1'b1);
        step(1'b0);
        check("double_latency", {31'd0, o_double}, 32'd1);
        clear_counts();
        step(1'b0);
        check("double_width", {31'd0, o_double}, 32'd0);
        repeat (30) step(1'b0);
        check("double_no_short", ev_cnt[0], 0);

        // Re-press on the exact tick that would time out the gap.
        do_reset();
        step(1'b0);
        repeat (8) step(1'b1);
        repeat (19) step(1'b0);
        step(1'b1);
        check("edge_wins_short", {31'd0, o_short}, 32'd0);
        check("edge_wins_busy", {31'd0, o_busy}, 32'd1);
        repeat (3) step(1'b1);
        step(1'b0);
        check("edge_wins_double", {31'd0, o_double}, 32'd1);

        // Reset during PRESS1.
        do_reset();
        step(1'b0);
        repeat (5) step(1'b1);
        check("press1_busy", {31'd0, o_busy}, 32'd1);
        do_reset();
        expect_quiet_after_reset("post_rst_press1");

        // Reset during GAP.
        step(1'b0);
        repeat (8) step(1'b1);
        repeat (3) step(1'b0);
        check("gap_busy", {31'd0, o_busy}, 32'd1);
        do_reset();
        expect_quiet_after_reset("post_rst_gap");

        // Reset during HELD, while the o_long pulse is high.
        step(1'b0);
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 100) begin
            step(1'b1);
            n++;
            if (o_long) seen = 1'b1;
        end
        check("held_long_seen", {31'd0, seen}, 32'd1);
        do_reset();
        expect_quiet_after_reset("post_rst_held");

        // Random press/release segments against the model.
        lvl = 1'b0;
        for (int s = 0; s < 80; s++) begin
            repeat ($urandom_range(1, 60)) step(lvl);
            lvl = ~lvl;
        end
        repeat (40) step(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
